// File: rtl/tetris_input_pkg.sv
// tetris_input_pkg: button bit indices and operation type shared with the movement stage
package tetris_input_pkg;
  localparam int OP_W   = 5;
  localparam int RIGHT  = 0;
  localparam int LEFT   = 1;
  localparam int DOWN   = 2;
  localparam int ROTATE = 3;
  localparam int START  = 4;
  localparam int N_REP  = 3;
  typedef logic [OP_W-1:0] op_t;
  function automatic op_t drop_lr_conflict(input op_t op);
    op_t lr;
    lr = '0;
    lr[RIGHT] = 1'b1;
    lr[LEFT] = 1'b1;
    return (op[RIGHT] && op[LEFT]) ? (op & ~lr) : op;
  endfunction
endpackage

// File: rtl/tetris_input_debounce.sv
// button_debounce: 2-flop synchroniser, stable-level debounce counter and press pulse
module button_debounce #(
  parameter int CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);
  logic [1:0] sync_q, sync_d;
  logic level_q, level_d, flip;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    sync_d = {sync_q[0], raw};
    flip = (sync_q[1] != level_q) && (cnt_q == LAST);
    cnt_d = (sync_q[1] == level_q || flip) ? '0 : cnt_q + 1'b1;
    level_d = level_q ^ flip;
    press = flip & ~level_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      level_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync_q <= sync_d;
      level_q <= level_d;
      cnt_q <= cnt_d;
    end
  end
  assign level = level_q;
endmodule

// File: rtl/tetris_input.sv
// tetris_input: debounced buttons turned into one registered command word per video frame
module tetris_input
  import tetris_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DAS_FRAMES      = 10,
  parameter int ARR_FRAMES      = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [OP_W-1:0] btn,
  input  logic            vsync,
  output logic [OP_W-1:0] operation,
  output logic            frame_strobe
);
  localparam logic [7:0] DAS = 8'(DAS_FRAMES);
  localparam logic [7:0] ARR_LAST = 8'(ARR_FRAMES - 1);
  op_t level, press, fire, pending_q, pending_d, operation_q, operation_d;
  logic [2:0] vs_q, vs_d;
  logic fall, frame_strobe_q, frame_strobe_d;
  logic [7:0] hold_q [N_REP];
  logic [7:0] hold_d [N_REP];
  logic [7:0] phase_q [N_REP];
  logic [7:0] phase_d [N_REP];
  logic unused_level;
  for (genvar g = 0; g < OP_W; g++) begin : g_btn
    button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock(clock),
      .reset(reset),
      .raw(btn[g]),
      .level(level[g]),
      .press(press[g])
    );
  end
  assign unused_level = ^level[OP_W-1:N_REP];
  // vs_q: two synchroniser stages, then the previous synchronised level
  always_comb begin
    vs_d = {vs_q[1:0], vsync};
    fall = vs_q[2] & ~vs_q[1];
    fire = '0;
    hold_d = hold_q;
    phase_d = phase_q;
    for (int i = 0; i < N_REP; i++) begin
      fire[i] = level[i] && (hold_q[i] >= DAS) && (phase_q[i] == 8'd0);
      if (!level[i]) begin
        hold_d[i] = 8'd0;
        phase_d[i] = 8'd0;
      end else if (fall) begin
        hold_d[i] = (hold_q[i] == 8'hff) ? hold_q[i] : hold_q[i] + 8'd1;
        phase_d[i] = (hold_q[i] < DAS || phase_q[i] == ARR_LAST) ? 8'd0 : phase_q[i] + 8'd1;
      end
    end
    operation_d = fall ? drop_lr_conflict(pending_q | fire) : operation_q;
    frame_strobe_d = fall;
    pending_d = fall ? press : (pending_q | press);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      vs_q <= '0;
      pending_q <= '0;
      operation_q <= '0;
      frame_strobe_q <= 1'b0;
      hold_q <= '{default: 8'd0};
      phase_q <= '{default: 8'd0};
    end else begin
      vs_q <= vs_d;
      pending_q <= pending_d;
      operation_q <= operation_d;
      frame_strobe_q <= frame_strobe_d;
      hold_q <= hold_d;
      phase_q <= phase_d;
    end
  end
  assign operation = operation_q;
  assign frame_strobe = frame_strobe_q;
endmodule

// File: tb/tb_tetris_input.sv
// tb_tetris_input: directed frame table, corner sequences and random stimulus against a frame-level model
module tb_tetris_input;
  import tetris_input_pkg::*;
  localparam int DEB = 4;
  localparam int DAS = 2;
  localparam int ARR = 2;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [4:0] btn = '0;
  logic vsync = 1'b0;
  logic [4:0] operation;
  logic frame_strobe;
  int vectors = 0;
  int miscompares = 0;
  int strobes = 0;
  tetris_input #(.DEBOUNCE_CYCLES(DEB), .DAS_FRAMES(DAS), .ARR_FRAMES(ARR)) dut (
    .clock(clock),
    .reset(reset),
    .btn(btn),
    .vsync(vsync),
    .operation(operation),
    .frame_strobe(frame_strobe)
  );
  always #5 clock = ~clock;

  logic [4:0] m_s1 = '0, m_s2 = '0, m_deb = '0, m_pend = '0, m_op = '0;
  logic m_v1 = 1'b0, m_v2 = 1'b0, m_vp = 1'b0, m_stb = 1'b0;
  int m_run [5];
  int m_hold [3];

  task automatic model_step();
    logic fall;
    logic [4:0] pub, press;
    int run;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_pend = '0; m_op = '0;
      m_v1 = 1'b0; m_v2 = 1'b0; m_vp = 1'b0; m_stb = 1'b0;
      foreach (m_run[i]) m_run[i] = 0;
      foreach (m_hold[i]) m_hold[i] = 0;
      return;
    end
    fall = m_vp && !m_v2;
    pub = m_pend;
    for (int i = 0; i < 3; i++)
      if (m_deb[i] && m_hold[i] >= DAS && (m_hold[i] - DAS) % ARR == 0) pub[i] = 1'b1;
    if (pub[RIGHT] && pub[LEFT]) begin
      pub[RIGHT] = 1'b0;
      pub[LEFT] = 1'b0;
    end
    for (int i = 0; i < 3; i++) m_hold[i] = !m_deb[i] ? 0 : m_hold[i] + (fall ? 1 : 0);
    press = '0;
    for (int i = 0; i < 5; i++) begin
      run = (m_s2[i] != m_deb[i]) ? m_run[i] + 1 : 0;
      if (run == DEB) begin
        m_deb[i] = ~m_deb[i];
        press[i] = m_deb[i];
        run = 0;
      end
      m_run[i] = run;
    end
    if (fall) m_op = pub;
    m_stb = fall;
    m_pend = fall ? press : (m_pend | press);
    m_vp = m_v2; m_v2 = m_v1; m_v1 = vsync;
    m_s2 = m_s1; m_s1 = btn;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    check("cycle_op", 32'(operation), 32'(m_op));
    check("cycle_strobe", 32'(frame_strobe), 32'(m_stb));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic cyc(input logic [4:0] b, input logic v, input logic r);
    btn = b;
    vsync = v;
    reset = r;
    @(posedge clock);
    @(negedge clock);
    if (frame_strobe) strobes++;
  endtask

  task automatic frame(input logic [4:0] b, input int s, input int e, input int hi);
    strobes = 0;
    for (int c = 0; c < hi + 8; c++) cyc((c >= s && c < e) ? b : 5'd0, c < hi, 1'b0);
  endtask

  typedef struct {
    logic [4:0] b;
    int s;
    int e;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl[$];
  logic [4:0] rb;

  initial begin
    tbl.push_back('{5'b00000, 0, 0, 5'b00000});
    tbl.push_back('{5'b01000, 0, 3, 5'b00000});
    tbl.push_back('{5'b00000, 0, 0, 5'b00000});
    tbl.push_back('{5'b01000, 0, 6, 5'b01000});
    tbl.push_back('{5'b00000, 0, 0, 5'b00000});
    for (int k = 0; k < 10; k++) tbl.push_back('{5'b00001, 0, 16, (k % 2 == 0) ? 5'b00001 : 5'b00000});
    tbl.push_back('{5'b00000, 0, 0, 5'b00000});
    tbl.push_back('{5'b00000, 0, 0, 5'b00000});
    tbl.push_back('{5'b00111, 0, 16, 5'b00100});
    tbl.push_back('{5'b00000, 0, 0, 5'b00000});
    tbl.push_back('{5'b10000, 5, 16, 5'b00000});
    tbl.push_back('{5'b10000, 0, 16, 5'b10000});
    tbl.push_back('{5'b10000, 0, 16, 5'b00000});
    tbl.push_back('{5'b00000, 0, 0, 5'b00000});
    repeat (3) cyc('0, 1'b0, 1'b1);
    check("reset_op", 32'(operation), 32'd0);
    check("reset_strobe", 32'(frame_strobe), 32'd0);
    repeat (4) cyc('0, 1'b1, 1'b0);
    repeat (2) cyc('0, 1'b0, 1'b1);
    strobes = 0;
    repeat (4) cyc('0, 1'b0, 1'b0);
    check("no_frame_after_reset", 32'(strobes), 32'd0);
    foreach (tbl[k]) begin
      frame(tbl[k].b, tbl[k].s, tbl[k].e, 8);
      check($sformatf("tbl%0d_op", k), 32'(operation), 32'(tbl[k].exp));
      check($sformatf("tbl%0d_strobes", k), 32'(strobes), 32'd1);
    end
    strobes = 0;
    for (int c = 0; c < 32; c++) cyc(((c < 6) || (c >= 12 && c < 18)) ? 5'b00001 : 5'b00000, c < 24, 1'b0);
    check("double_press_op", 32'(operation), 32'd1);
    check("double_press_strobes", 32'(strobes), 32'd1);
    frame('0, 0, 0, 8);
    check("after_double_op", 32'(operation), 32'd0);
    strobes = 0;
    for (int c = 0; c < 16; c++) begin
      btn = '0;
      reset = 1'b0;
      vsync = c < 8;
      if (c == 3) begin
        vsync = 1'b0;
        #3;
        vsync = 1'b1;
      end
      @(posedge clock);
      @(negedge clock);
      if (frame_strobe) strobes++;
    end
    check("vsync_glitch_strobes", 32'(strobes), 32'd1);
    frame(5'b00100, 0, 16, 8);
    check("down_op", 32'(operation), 32'b00100);
    for (int c = 0; c < 16; c++) begin
      cyc((c < 4) ? 5'b00100 : 5'b00000, c < 8, c == 4 || c == 5);
      if (c == 4) check("reset_mid_hold_op", 32'(operation), 32'd0);
    end
    check("post_reset_frame_op", 32'(operation), 32'd0);
    repeat (2) begin
      frame('0, 0, 0, 8);
      check("down_not_republished", 32'(operation), 32'd0);
    end
    frame(5'b00100, 0, 16, 8);
    check("down_repressed_op", 32'(operation), 32'b00100);
    frame('0, 0, 0, 8);
    check("down_released_op", 32'(operation), 32'd0);
    rb = '0;
    for (int f = 0; f < 80; f++) begin
      int hi, lo, s, e, gc, rc;
      logic full;
      hi = $urandom_range(3, 12);
      lo = $urandom_range(3, 12);
      if ($urandom_range(0, 2) == 0) rb = 5'($urandom);
      full = 1'($urandom_range(0, 1));
      s = full ? 0 : $urandom_range(0, hi + lo - 1);
      e = full ? hi + lo : $urandom_range(s, hi + lo);
      gc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, hi + lo - 1) : -1;
      rc = ($urandom_range(0, 19) == 0) ? $urandom_range(0, hi + lo - 1) : -1;
      for (int c = 0; c < hi + lo; c++)
        cyc((c >= s && c < e) ? rb : 5'd0, (c < hi) ^ (c == gc), c == rc);
    end
    repeat (4) cyc('0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tetris_input.md
TETRIS_INPUT -- requirements
Module: tetris_input

Interface
REQ-001 The block SHALL expose parameter DEBOUNCE_CYCLES, default 250000, meaning consecutive clock cycles of stable raw level required to accept a button change.
REQ-002 The block SHALL expose parameter DAS_FRAMES, default 10, meaning frames a repeatable button must be held before its first auto-repeat.
REQ-003 The block SHALL expose parameter ARR_FRAMES, default 3, meaning frames between later auto-repeats.
REQ-004 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clock  input  1  single system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- btn  input  5  raw asynchronous push buttons, active-high, bit order RIGHT=0, LEFT=1, DOWN=2, ROTATE=3, START=4.
- vsync  input  1  VGA vertical sync, asynchronous to this logic; a falling edge marks a frame boundary.
- operation  output  5  registered per-frame command to the piece-movement stage, same bit order as btn.
- frame_strobe  output  1  one-cycle pulse in the cycle operation updates.

Function
REQ-005 Each btn bit and vsync SHALL pass through a 2-flop synchroniser before any other use.
REQ-006 Each button SHALL have a debounce counter that clears whenever the synchronised level equals the debounced level, and the debounced level SHALL take the new value only after DEBOUNCE_CYCLES consecutive differing cycles.
REQ-007 A 0->1 transition of a debounced button SHALL set that button's pending bit, which stays set until the next publish.
REQ-008 A frame boundary SHALL be detected as synchronised vsync 1 then 0 on consecutive cycles, and SHALL produce exactly one publish cycle.
REQ-009 On a publish cycle: operation <= pending | repeat_fire, frame_strobe <= 1, and pending <= 0, except that a press event in that same cycle SHALL remain pending for the next frame.
REQ-010 operation SHALL hold its value unchanged between publish cycles, with latency from press edge to visibility of at most one frame plus one cycle.
REQ-011 RIGHT, LEFT and DOWN SHALL auto-repeat using a per-button 8-bit hold-frame counter that increments on each publish while the button is debounced-held, saturates at 255, and clears on release.
REQ-012 repeat_fire SHALL assert for a held button when its hold count equals DAS_FRAMES, and again whenever (count - DAS_FRAMES) is a positive multiple of ARR_FRAMES.
REQ-013 At saturation, repeat_fire SHALL continue every ARR_FRAMES using a separate ARR phase counter.
REQ-014 ROTATE and START SHALL never auto-repeat, so one press yields exactly one published frame.
REQ-015 If RIGHT and LEFT would both be published in the same frame, both bits SHALL be forced to 0, while the other bits are unaffected.
REQ-016 Multiple presses of one button within one frame SHALL publish as a single 1.
REQ-017 frame_strobe SHALL be 0 in all non-publish cycles.

Reset
REQ-018 While reset=1, the block SHALL force operation=0, frame_strobe=0, debounced levels=0, pending=0, all debounce, hold and phase counters=0, and synchroniser flops=0.
REQ-019 Reset asserted mid-debounce or mid-hold SHALL discard that progress, and a button still held after reset SHALL publish a press only once it has debounced as a fresh 0->1 transition.
REQ-020 No frame boundary SHALL be detected in the first cycle after reset deasserts.

Structure
REQ-021 A shared package SHALL hold the bit indices RIGHT/LEFT/DOWN/ROTATE/START and OP_W=5, for use by this block and the movement stage.
REQ-022 A sub-module button_debounce, holding the synchroniser, debounce counter and edge output, SHALL be instantiated once per button.
REQ-023 Frame detection, pending, repeat and conflict logic SHALL live in tetris_input.

Verification (DEBOUNCE_CYCLES=4, DAS_FRAMES=2, ARR_FRAMES=2)
REQ-024 Bench SHALL cover: ROTATE pulse high for 3 cycles -> operation never shows bit 3; the same held for 6 cycles -> operation=5'b01000 for exactly one frame, with frame_strobe pulsing once per vsync fall.
REQ-025 Bench SHALL cover: RIGHT held 10 frames -> bit 0 published at frames 1, 3, 5, 7, 9 after press and 0 elsewhere.
REQ-026 Bench SHALL cover: RIGHT and LEFT pressed in the same frame, together with DOWN -> operation=5'b00100.
REQ-027 Bench SHALL cover: a START debounced edge coinciding with the publish cycle -> absent from this frame, and 5'b10000 at the next frame.
REQ-028 Bench SHALL cover: DOWN held, then reset pulsed for 2 cycles mid-hold -> operation=0 immediately, and DOWN not republished until released and re-pressed.
REQ-029 Bench SHALL cover: vsync glitch shorter than 2 cycles -> at most one frame_strobe per clean falling edge.
